fp_matvec_sequencer: RTL and testbench
======================================

Name: fp_matvec_sequencer

Overview:
Sequences a matrix-vector product y = M*v (+bias) through one shared fp_dot_product instance, one matrix row per issue slot. Reads rows from an external row memory, drives the dot product's a/b/c/enable/ready inputs, and counts returning valid results. Returns each result tagged with its row index, and signals completion. Sits between the LCMV control FSM and the dot-product datapath.

Parameters:
WIDTH, 32, float word width.
NUM_INPUTS, 5, dot-product vector length (max columns).
MAX_ROWS, 16, max rows per operation.
ROW_ADDR_W, $clog2(MAX_ROWS), row address / index width.
NCOL_W, $clog2(NUM_INPUTS+1), width of n_cols.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset; shared with the dot product.
start  in  1  one-cycle request; sampled only in IDLE.
n_rows  in  ROW_ADDR_W+1  rows to process, legal 1..MAX_ROWS; sampled with start.
n_cols  in  NCOL_W  active columns, legal 1..NUM_INPUTS; sampled with start.
bias_en  in  1  if 1, c = bias, else c = +0.0; sampled with start.
bias  in  WIDTH  bias value; sampled with start.
hold  in  1  stall: suppresses new row reads while high.
vec  in  WIDTH*NUM_INPUTS  vector v; held stable by the requester while busy.
busy  out  1  high in ISSUE and DRAIN.
done  out  1  one-cycle completion pulse.
cfg_err  out  1  one-cycle pulse on rejected start.
row_rd_en  out  1  row memory read strobe.
row_rd_addr  out  ROW_ADDR_W  row address.
row_rd_data  in  WIDTH*NUM_INPUTS  row data, valid exactly 1 cycle after row_rd_en.
dp_a  out  WIDTH*NUM_INPUTS  = row_rd_data (combinational pass-through).
dp_b  out  WIDTH*NUM_INPUTS  = vec.
dp_c  out  WIDTH  latched bias or 32'h0.
dp_enable  out  NUM_INPUTS  low n_cols bits set.
dp_ready  out  1  issue strobe to the dot product.
dp_out  in  WIDTH  dot-product result.
dp_valid  in  1  dot-product result valid.
res_valid  out  1  result strobe; no backpressure, so the consumer must accept every strobe.
res_data  out  WIDTH  = dp_out.
res_idx  out  ROW_ADDR_W  row index of res_data.

Behaviour:
- Clock is clk. rst is synchronous and active-high. It is shared with the dot product, which clears that unit's valid pipeline.
- Reset: state = IDLE and all counters = 0. busy, done, cfg_err, row_rd_en, dp_ready and res_valid are 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE, start with legal n_rows and n_cols:
  - Latch n_rows, n_cols, bias_en and bias.
  - Clear issue_cnt and res_cnt.
  - Go to ISSUE.
- IDLE, start with illegal config (n_rows = 0, n_rows > MAX_ROWS, n_cols = 0, or n_cols > NUM_INPUTS):
  - cfg_err = 1 on the next cycle; stay in IDLE.
- start outside IDLE is ignored (no error).
- ISSUE:
  - row_rd_en = !hold. row_rd_addr = issue_cnt; issue_cnt increments on each read.
  - After the read with issue_cnt = n_rows-1, go to DRAIN.
- dp_ready is row_rd_en registered 1 cycle, so it aligns with row_rd_data; hold never cancels a pending dp_ready.
- dp_enable = (1 << n_cols_latched) - 1. dp_c = bias_en_latched ? bias_latched : 0.
- Results:
  - res_valid = dp_valid && (ISSUE or DRAIN). res_idx = res_cnt.
  - res_cnt increments on each res_valid.
  - dp_valid in IDLE or DONE is dropped.
  - Results return in issue order because the dot-product latency is fixed.
- DRAIN: when res_cnt reaches n_rows_latched (after the final res_valid), go to DONE. Results in ISSUE are counted too.
- DONE: done = 1 and busy = 0 for exactly 1 cycle, then IDLE. A start in that cycle is ignored.
- Throughput: 1 row per cycle without hold. Cycles from start to done = n_rows + 2 + L_dp, where L_dp is the dot-product ready->valid latency.
- Reset mid-operation: next cycle is IDLE with no done. In-flight results are never presented.

Test Plan:
1. n_rows=3, n_cols=5, bias_en=0, vec=[1,2,3,4,5], rows = unit vectors e0,e1,e2 -> res (idx,data) = (0,1.0), (1,2.0), (2,3.0); done 1 cycle after idx 2; row_rd_addr 0,1,2 on consecutive cycles.
2. n_rows=2, n_cols=3, bias_en=1, bias=0.5, rows and vec all 1.0 -> dp_enable=5'b00111; both results 3.5; dp_c=32'h3F000000.
3. n_rows=4, hold high for 3 cycles after the second read -> addrs 0,1, a 3-cycle gap, then 2,3; exactly 4 rd_en and 4 dp_ready pulses; results idx 0..3 in order; single done.
4. start with n_rows=0, then with n_cols=6 -> cfg_err pulse each time, no row_rd_en, busy stays 0; start while busy -> ignored, result count unchanged.
5. n_rows=16 and rst asserted in DRAIN after 5 results -> busy=0 next cycle, no done, no further res_valid; a following start with n_rows=2 completes normally with idx 0,1.
6. n_rows=16, no hold -> 16 back-to-back reads, addrs 0..15; res_idx 0..15 with no wrap or duplicate; done exactly once at start + 18 + L_dp.

Source files
------------

// File: rtl/fp_matvec_sequencer.sv
// fp_matvec_sequencer: issues one matrix row per cycle into a shared dot-product
// unit to form y = M*v (+bias), and tags each returning result with its row index.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (shared with the dot product)
//   start               one-cycle request, sampled only in IDLE
//   n_rows, n_cols      operation shape, sampled with start
//   bias_en, bias       optional bias for the c input, sampled with start
//   hold                stall, suppresses new row reads while high
//   vec                 vector v, held stable by the requester while busy
//   busy, done, cfg_err status: busy in ISSUE/DRAIN, done and cfg_err are one-cycle pulses
//   row_rd_en/addr/data row memory read port (data valid one cycle after rd_en)
//   dp_a/b/c/enable/ready  drive side of the dot-product unit
//   dp_out, dp_valid    result side of the dot-product unit
//   res_valid/data/idx  tagged result stream (no backpressure)
module fp_matvec_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_INPUTS = 5,
  parameter int unsigned MAX_ROWS   = 16,
  parameter int unsigned ROW_ADDR_W = $clog2(MAX_ROWS),
  parameter int unsigned NCOL_W     = $clog2(NUM_INPUTS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ROW_ADDR_W:0]           n_rows,
  input  logic [NCOL_W-1:0]             n_cols,
  input  logic                          bias_en,
  input  logic [WIDTH-1:0]              bias,
  input  logic                          hold,
  input  logic [WIDTH*NUM_INPUTS-1:0]   vec,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err,
  output logic                          row_rd_en,
  output logic [ROW_ADDR_W-1:0]         row_rd_addr,
  input  logic [WIDTH*NUM_INPUTS-1:0]   row_rd_data,
  output logic [WIDTH*NUM_INPUTS-1:0]   dp_a,
  output logic [WIDTH*NUM_INPUTS-1:0]   dp_b,
  output logic [WIDTH-1:0]              dp_c,
  output logic [NUM_INPUTS-1:0]         dp_enable,
  output logic                          dp_ready,
  input  logic [WIDTH-1:0]              dp_out,
  input  logic                          dp_valid,
  output logic                          res_valid,
  output logic [WIDTH-1:0]              res_data,
  output logic [ROW_ADDR_W-1:0]         res_idx
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state;
  logic [ROW_ADDR_W-1:0] issue_cnt;
  logic [ROW_ADDR_W-1:0] res_cnt;
  logic [ROW_ADDR_W-1:0] last_row;   // n_rows - 1, so both counters compare without widening
  logic                  cfg_ok;
  logic                  in_op;

  // Legal shape: 1..MAX_ROWS rows and 1..NUM_INPUTS columns.
  assign cfg_ok = (n_rows != '0) && (n_rows <= (ROW_ADDR_W+1)'(MAX_ROWS)) &&
                  (n_cols != '0) && (n_cols <= NCOL_W'(NUM_INPUTS));

  assign in_op = (state == ISSUE) || (state == DRAIN);

  // Read strobe reacts to hold in the same cycle so a stall costs no extra gap.
  assign row_rd_en   = (state == ISSUE) && !hold;
  assign row_rd_addr = issue_cnt;

  assign dp_a = row_rd_data;
  assign dp_b = vec;

  // Results outside an operation (e.g. stale pipeline contents) are dropped.
  assign res_valid = dp_valid && in_op;
  assign res_data  = dp_out;
  assign res_idx   = res_cnt;

  // Control FSM, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      res_cnt   <= '0;
      last_row  <= '0;
      dp_c      <= '0;
      dp_enable <= '0;
      dp_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      // Row data returns one cycle after the read, so ready trails rd_en by one.
      dp_ready <= row_rd_en;

      if (row_rd_en) issue_cnt <= issue_cnt + ROW_ADDR_W'(1);
      if (res_valid) res_cnt   <= res_cnt + ROW_ADDR_W'(1);

      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              last_row  <= ROW_ADDR_W'(n_rows - (ROW_ADDR_W+1)'(1));
              dp_c      <= bias_en ? bias : '0;
              for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                dp_enable[i] <= (i < 32'(n_cols));
              end
              issue_cnt <= '0;
              res_cnt   <= '0;
              busy      <= 1'b1;
              state     <= ISSUE;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (row_rd_en && (issue_cnt == last_row)) state <= DRAIN;
        end
        DRAIN: begin
          if (res_valid && (res_cnt == last_row)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_matvec_sequencer.sv
// Directed bench for fp_matvec_sequencer with a row memory and a fixed-latency
// floating-point dot-product model.
module tb_fp_matvec_sequencer;

  localparam int W    = 32;
  localparam int N    = 5;
  localparam int AW   = 4;
  localparam int CW   = 3;
  localparam int L_DP = 12;

  localparam logic [31:0] F1  = 32'h3F800000;
  localparam logic [31:0] F2  = 32'h40000000;
  localparam logic [31:0] F3  = 32'h40400000;
  localparam logic [31:0] F4  = 32'h40800000;
  localparam logic [31:0] F5  = 32'h40A00000;
  localparam logic [31:0] FH  = 32'h3F000000;
  localparam logic [31:0] F35 = 32'h40600000;

  logic clk = 1'b0;
  logic rst, start, bias_en, hold;
  logic [AW:0] n_rows;
  logic [CW-1:0] n_cols;
  logic [W-1:0] bias;
  logic [W*N-1:0] vec;
  logic busy, done, cfg_err, row_rd_en, dp_ready, dp_valid, res_valid;
  logic [AW-1:0] row_rd_addr, res_idx;
  logic [W*N-1:0] row_rd_data, dp_a, dp_b;
  logic [W-1:0] dp_c, dp_out, res_data;
  logic [N-1:0] dp_enable;

  always #5 clk = ~clk;

  fp_matvec_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .n_rows(n_rows), .n_cols(n_cols),
    .bias_en(bias_en), .bias(bias), .hold(hold), .vec(vec), .busy(busy),
    .done(done), .cfg_err(cfg_err), .row_rd_en(row_rd_en), .row_rd_addr(row_rd_addr),
    .row_rd_data(row_rd_data), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
    .dp_enable(dp_enable), .dp_ready(dp_ready), .dp_out(dp_out), .dp_valid(dp_valid),
    .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx)
  );

  // ---------------- float helpers (normal numbers and zero) ----------------
  function automatic real f2r(input logic [31:0] x);
    real r;
    int e;
    if (x[30:0] == 31'd0) return 0.0;
    r = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return x[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    real a;
    int e;
    logic s;
    logic [22:0] m;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = 23'($rtoi((a - 1.0) * 8388608.0 + 0.5));
    return {s, 8'(e), m};
  endfunction

  function automatic logic [31:0] dot(input logic [W*N-1:0] a, input logic [W*N-1:0] b,
                                      input logic [W-1:0] c, input logic [N-1:0] en);
    real acc;
    acc = f2r(c);
    for (int i = 0; i < N; i++)
      if (en[i]) acc = acc + f2r(a[W*i +: W]) * f2r(b[W*i +: W]);
    return r2f(acc);
  endfunction

  // ---------------- row memory and dot-product model ----------------
  logic [W*N-1:0] rows [16];

  always @(posedge clk) if (row_rd_en) row_rd_data <= rows[row_rd_addr];

  logic [W-1:0] pipe_d [L_DP];
  logic         pipe_v [L_DP];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L_DP; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= dp_ready;
      pipe_d[0] <= dot(dp_a, dp_b, dp_c, dp_enable);
      for (int i = 1; i < L_DP; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign dp_valid = pipe_v[L_DP-1];
  assign dp_out   = pipe_d[L_DP-1];

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int addr_q[$], addr_cyc_q[$], idx_q[$], res_cyc_q[$];
  logic [31:0] data_q[$];
  int rdy_cnt = 0, done_cnt = 0, done_cyc = 0, cfg_cnt = 0, busy_cnt = 0;

  always @(negedge clk) begin
    if (row_rd_en) begin addr_q.push_back(int'(row_rd_addr)); addr_cyc_q.push_back(cyc); end
    if (dp_ready) rdy_cnt++;
    if (res_valid) begin
      idx_q.push_back(int'(res_idx));
      data_q.push_back(res_data);
      res_cyc_q.push_back(cyc);
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (cfg_err) cfg_cnt++;
    if (busy) busy_cnt++;
  end

  int b_addr, b_res, b_rdy, b_done, b_cfg, b_busy, start_cyc;

  task automatic mark();
    b_addr = addr_q.size(); b_res = idx_q.size(); b_rdy = rdy_cnt;
    b_done = done_cnt; b_cfg = cfg_cnt; b_busy = busy_cnt;
  endtask

  // ---------------- checking ----------------
  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W*N-1:0] unit_row(input int i);
    logic [W*N-1:0] r;
    r = '0;
    r[W*i +: W] = F1;
    return r;
  endfunction

  // Runs one operation; hs/hl give a hold window and xs an extra start, in cycles after start.
  task automatic run_op(input int nr, input int nc, input logic ben, input logic [31:0] b,
                        input int hs, input int hl, input int xs);
    mark();
    start_cyc = cyc;
    n_cols = CW'(nc); bias_en = ben; bias = b;
    for (int k = 0; k < 200; k++) begin
      start  = (k == 0) || (k == xs);
      n_rows = (k == xs) ? (AW+1)'(1) : (AW+1)'(nr);
      hold   = (k >= hs) && (k < hs + hl);
      tick();
      if (done_cnt > b_done) break;
    end
    start = 1'b0; hold = 1'b0;
    repeat (3) tick();
    check("op_done_once", done_cnt - b_done, 1);
  endtask

  task automatic cfg_try(input int nr, input int nc, input string tag);
    mark();
    n_rows = (AW+1)'(nr); n_cols = CW'(nc); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check({tag, "_cfg_err"}, cfg_cnt - b_cfg, 1);
    check({tag, "_no_rd"}, addr_q.size() - b_addr, 0);
    check({tag, "_no_busy"}, busy_cnt - b_busy, 0);
  endtask

  logic [31:0] ve [N];
  int cnt, k;

  initial begin
    ve[0] = F1; ve[1] = F2; ve[2] = F3; ve[3] = F4; ve[4] = F5;
    rst = 1'b1; start = 1'b0; hold = 1'b0; bias_en = 1'b0; bias = '0;
    n_rows = '0; n_cols = '0;
    vec = {F5, F4, F3, F2, F1};
    for (int i = 0; i < 16; i++) rows[i] = unit_row(i % 5);
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_rd_en", row_rd_en, 0);
    check("rst_dp_ready", dp_ready, 0);
    check("rst_res_valid", res_valid, 0);
    rst = 1'b0;
    tick();

    // 1: unit rows pick vector elements
    run_op(3, 5, 1'b0, 32'h0, -1, 0, -1);
    check("t1_nres", idx_q.size() - b_res, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_idx%0d", i), idx_q[b_res+i], i);
      check($sformatf("t1_data%0d", i), data_q[b_res+i], ve[i]);
      check($sformatf("t1_addr%0d", i), addr_q[b_addr+i], i);
    end
    check("t1_addr_seq1", addr_cyc_q[b_addr+1] - addr_cyc_q[b_addr], 1);
    check("t1_addr_seq2", addr_cyc_q[b_addr+2] - addr_cyc_q[b_addr+1], 1);
    check("t1_done_after_last", done_cyc - res_cyc_q[b_res+2], 1);
    check("t1_latency", done_cyc - start_cyc, 3 + 2 + L_DP);

    // 2: partial columns with bias
    for (int i = 0; i < 16; i++) rows[i] = {F1, F1, F1, F1, F1};
    vec = {F1, F1, F1, F1, F1};
    mark();
    n_rows = (AW+1)'(2); n_cols = CW'(3); bias_en = 1'b1; bias = FH; start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_enable", 32'(dp_enable), 32'h07);
    check("t2_dp_c", dp_c, FH);
    check("t2_busy", busy, 1);
    for (k = 0; k < 100 && done_cnt == b_done; k++) tick();
    check("t2_done", done_cnt - b_done, 1);
    check("t2_nres", idx_q.size() - b_res, 2);
    for (int i = 0; i < 2; i++) check($sformatf("t2_data%0d", i), data_q[b_res+i], F35);

    // 3: hold for three cycles after the second read
    vec = {F5, F4, F3, F2, F1};
    for (int i = 0; i < 16; i++) rows[i] = unit_row(i % 5);
    run_op(4, 5, 1'b0, 32'h0, 3, 3, -1);
    check("t3_nrd", addr_q.size() - b_addr, 4);
    check("t3_nrdy", rdy_cnt - b_rdy, 4);
    check("t3_gap", addr_cyc_q[b_addr+2] - addr_cyc_q[b_addr+1], 4);
    check("t3_nres", idx_q.size() - b_res, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_addr%0d", i), addr_q[b_addr+i], i);
      check($sformatf("t3_idx%0d", i), idx_q[b_res+i], i);
      check($sformatf("t3_data%0d", i), data_q[b_res+i], ve[i]);
    end

    // 4: illegal configs, then a start while busy
    cfg_try(0, 5, "t4_rows0");
    cfg_try(17, 5, "t4_rows17");
    cfg_try(3, 6, "t4_cols6");
    cfg_try(3, 0, "t4_cols0");
    run_op(3, 5, 1'b0, 32'h0, -1, 0, 2);
    check("t4_nres", idx_q.size() - b_res, 3);
    check("t4_nrd", addr_q.size() - b_addr, 3);
    check("t4_no_cfg_err", cfg_cnt - b_cfg, 0);

    // 5: reset during drain, then a clean short operation
    mark();
    n_rows = (AW+1)'(16); n_cols = CW'(5); bias_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (k = 0; k < 100 && (idx_q.size() - b_res) < 5; k++) tick();
    check("t5_reached5", 32'((idx_q.size() - b_res) >= 5), 1);
    check("t5_in_drain", addr_q.size() - b_addr, 16);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy_after_rst", busy, 0);
    cnt = idx_q.size() - b_res;
    repeat (30) tick();
    check("t5_no_more_res", idx_q.size() - b_res, cnt);
    check("t5_no_done", done_cnt - b_done, 0);
    for (int i = 0; i < cnt; i++) check($sformatf("t5_idx%0d", i), idx_q[b_res+i], i);
    run_op(2, 5, 1'b0, 32'h0, -1, 0, -1);
    check("t5_post_nres", idx_q.size() - b_res, 2);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t5_post_idx%0d", i), idx_q[b_res+i], i);
      check($sformatf("t5_post_data%0d", i), data_q[b_res+i], ve[i]);
    end

    // 6: full 16-row operation, back to back
    run_op(16, 5, 1'b0, 32'h0, -1, 0, -1);
    check("t6_nrd", addr_q.size() - b_addr, 16);
    check("t6_nres", idx_q.size() - b_res, 16);
    check("t6_latency", done_cyc - start_cyc, 16 + 2 + L_DP);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t6_addr%0d", i), addr_q[b_addr+i], i);
      check($sformatf("t6_idx%0d", i), idx_q[b_res+i], i);
      check($sformatf("t6_data%0d", i), data_q[b_res+i], ve[i % 5]);
      if (i > 0) check($sformatf("t6_back2back%0d", i), addr_cyc_q[b_addr+i] - addr_cyc_q[b_addr+i-1], 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
